// File: rtl/inst_fetch_queue_if.sv
// Bus signals of the fetch queue: instruction-memory request/ack channel
// and the decode-side valid/ready channel.
interface inst_fetch_queue_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_ack_i;
  logic [DATA_W-1:0] imem_rdata_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [ADDR_W-1:0] id_pc_o;
  logic [DATA_W-1:0] id_inst_o;

  modport master (
    output imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o,
    input  imem_ack_i, imem_rdata_i, id_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o,
    output imem_ack_i, imem_rdata_i, id_ready_i
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: one outstanding imem request, results queued in a
// small {pc, inst} FIFO toward decode, with PC back-pressure and flush.
module inst_fetch_queue #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        pc_i,
  input  logic                     ce_i,
  input  logic                     flush_i,
  output logic                     stall_o,
  output logic [$clog2(DEPTH):0]   count_o,
  inst_fetch_queue_if.master       bus
);

  // state | meaning
  // IDLE  | no request outstanding
  // REQ   | request outstanding, result is kept
  // DRAIN | request outstanding, result is discarded (flushed)
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     count_q, count_d, cnt_nxt;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic              wr, rd, accept, do_wr, do_rd, head_vld;

  assign head_vld = (count_q != '0);
  assign wr       = (state_q == S_REQ) & bus.imem_ack_i;
  assign rd       = head_vld & bus.id_ready_i;
  assign cnt_nxt  = count_q + CW'(wr) - CW'(rd);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign accept   = ce_i & ~flush_i & ((state_q == S_IDLE) | wr) &
                    (cnt_nxt < CW'(DEPTH));
  assign stall_o  = ce_i & ~accept;
  assign do_wr    = wr & ~flush_i;
  assign do_rd    = rd & ~flush_i;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d = cnt_nxt;
      if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (accept) begin
      state_d = S_REQ;
      addr_d  = pc_i;
    end else begin
      case (state_q)
        S_REQ: begin
          if (bus.imem_ack_i)  state_d = S_IDLE;
          else if (flush_i)    state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (bus.imem_ack_i)  state_d = S_IDLE;
        end
        default:               state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
    end
  end

  // Storage needs no reset; the head outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      pc_mem[wr_ptr_q]   <= addr_q;
      inst_mem[wr_ptr_q] <= bus.imem_rdata_i;
    end
  end

  assign bus.imem_req_o  = (state_q == S_REQ) | (state_q == S_DRAIN);
  assign bus.imem_addr_o = addr_q;
  assign bus.id_valid_o  = head_vld;
  assign bus.id_pc_o     = head_vld ? pc_mem[rd_ptr_q]   : '0;
  assign bus.id_inst_o   = head_vld ? inst_mem[rd_ptr_q] : '0;
  assign count_o         = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus a
// randomized run against a queue-based behavioural model.
module tb_inst_fetch_queue;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] pc_i = '0;
  logic              ce_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              stall_o;
  logic [2:0]        count_o;

  inst_fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  inst_fetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .pc_i    (pc_i),
    .ce_i    (ce_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .count_o (count_o),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: outstanding-request flag, discard flag, request address, FIFO queue.
  bit                         m_out, m_disc;
  logic [ADDR_W-1:0]          m_addr;
  logic [ADDR_W+DATA_W-1:0]   mq[$];

  function automatic logic [31:0] f_inst(input logic [ADDR_W-1:0] a);
    return 32'h1234_0000 | {26'd0, a};
  endfunction

  function automatic bit f_accept();
    bit wr, rd;
    int nxt;
    wr  = m_out && !m_disc && bus.imem_ack_i;
    rd  = (mq.size() != 0) && bus.id_ready_i;
    nxt = mq.size() + int'(wr) - int'(rd);
    return ce_i && !flush_i && (!m_out || wr) && (nxt < DEPTH);
  endfunction

  function automatic void model_reset();
    m_out = 0; m_disc = 0; m_addr = '0; mq.delete();
  endfunction

  function automatic void model_update();
    bit wr, rd, acc;
    if (!rst) begin
      model_reset();
      return;
    end
    wr  = m_out && !m_disc && bus.imem_ack_i;
    rd  = (mq.size() != 0) && bus.id_ready_i;
    acc = f_accept();
    if (flush_i) begin
      mq.delete();
      if (m_out && bus.imem_ack_i) begin m_out = 0; m_disc = 0; end
      else if (m_out) m_disc = 1;
    end else begin
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back({m_addr, bus.imem_rdata_i});
      if (acc) begin m_out = 1; m_disc = 0; m_addr = pc_i; end
      else if (m_out && bus.imem_ack_i) begin m_out = 0; m_disc = 0; end
    end
  endfunction

  task automatic set_in(input logic ce, input logic [ADDR_W-1:0] pc, input logic fl,
                        input logic ack, input logic [DATA_W-1:0] rdata, input logic rdy);
    ce_i = ce; pc_i = pc; flush_i = fl;
    bus.imem_ack_i = ack; bus.imem_rdata_i = rdata; bus.id_ready_i = rdy;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    set_in(0, '0, 0, 0, '0, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    set_in(0, '0, 0, 0, '0, 0);
    tick();
    tick();
    n_total++; if (bus.imem_req_o !== 1'b0) $display("FAIL reset_req got=%0b exp=0", bus.imem_req_o); else n_pass++;
    n_total++; if (bus.imem_addr_o !== 6'd0) $display("FAIL reset_addr got=%0h exp=0", bus.imem_addr_o); else n_pass++;
    n_total++; if (bus.id_valid_o !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", bus.id_valid_o); else n_pass++;
    n_total++; if (bus.id_pc_o !== 6'd0) $display("FAIL reset_pc got=%0h exp=0", bus.id_pc_o); else n_pass++;
    n_total++; if (bus.id_inst_o !== 32'd0) $display("FAIL reset_inst got=%0h exp=0", bus.id_inst_o); else n_pass++;
    n_total++; if (count_o !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count_o); else n_pass++;
    n_total++; if (stall_o !== 1'b0) $display("FAIL reset_stall got=%0b exp=0", stall_o); else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    set_in(1, 6'h05, 0, 0, '0, 0);
    n_total++; if (stall_o !== 1'b0) $display("FAIL single_stall_idle got=%0b exp=0", stall_o); else n_pass++;
    n_total++; if (bus.imem_req_o !== 1'b0) $display("FAIL single_req_idle got=%0b exp=0", bus.imem_req_o); else n_pass++;
    tick();
    set_in(1, 6'h06, 0, 0, '0, 0);
    n_total++; if (bus.imem_req_o !== 1'b1) $display("FAIL single_req1 got=%0b exp=1", bus.imem_req_o); else n_pass++;
    n_total++; if (bus.imem_addr_o !== 6'h05) $display("FAIL single_addr got=%0h exp=5", bus.imem_addr_o); else n_pass++;
    n_total++; if (stall_o !== 1'b1) $display("FAIL single_stall_req got=%0b exp=1", stall_o); else n_pass++;
    tick();
    set_in(0, '0, 0, 1, 32'h2001000A, 0);
    n_total++; if (bus.imem_req_o !== 1'b1) $display("FAIL single_req2 got=%0b exp=1", bus.imem_req_o); else n_pass++;
    n_total++; if (bus.id_valid_o !== 1'b0) $display("FAIL single_valid_early got=%0b exp=0", bus.id_valid_o); else n_pass++;
    tick();
    set_in(0, '0, 0, 0, '0, 0);
    n_total++; if (bus.id_valid_o !== 1'b1) $display("FAIL single_valid got=%0b exp=1", bus.id_valid_o); else n_pass++;
    n_total++; if (bus.id_pc_o !== 6'h05) $display("FAIL single_pc got=%0h exp=5", bus.id_pc_o); else n_pass++;
    n_total++; if (bus.id_inst_o !== 32'h2001000A) $display("FAIL single_inst got=%0h exp=2001000a", bus.id_inst_o); else n_pass++;
    n_total++; if (bus.imem_req_o !== 1'b0) $display("FAIL single_req_done got=%0b exp=0", bus.imem_req_o); else n_pass++;
    n_total++; if (count_o !== 3'd1) $display("FAIL single_count got=%0d exp=1", count_o); else n_pass++;
    tick();
  endtask

  task automatic test_streaming();
    logic [ADDR_W-1:0] pc_next = '0;
    int exp_head = 0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      set_in(1, pc_next, 0, m_out, f_inst(m_addr), 1);
      n_total++; if (stall_o !== 1'b0) $display("FAIL stream_stall cyc=%0d got=%0b exp=0", i, stall_o); else n_pass++;
      if (i > 0) begin
        n_total++; if (bus.imem_req_o !== 1'b1) $display("FAIL stream_req cyc=%0d got=%0b exp=1", i, bus.imem_req_o); else n_pass++;
      end
      if (bus.id_valid_o) begin
        n_total++; if (bus.id_pc_o !== ADDR_W'(exp_head)) $display("FAIL stream_pc got=%0h exp=%0h", bus.id_pc_o, exp_head); else n_pass++;
        exp_head++;
      end
      pc_next++;
      tick();
    end
    n_total++; if (exp_head < 12) $display("FAIL stream_progress got=%0d exp>=12", exp_head); else n_pass++;
  endtask

  task automatic test_fill();
    logic [ADDR_W-1:0] pc_next = '0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1, pc_next, 0, m_out, f_inst(m_addr), 0);
      if (i >= 5) begin
        n_total++; if (stall_o !== 1'b1) $display("FAIL fill_stall cyc=%0d got=%0b exp=1", i, stall_o); else n_pass++;
      end
      if (!stall_o) pc_next++;
      tick();
    end
    n_total++; if (count_o !== 3'd4) $display("FAIL fill_count got=%0d exp=4", count_o); else n_pass++;
    n_total++; if (pc_next !== 6'd4) $display("FAIL fill_accepts got=%0d exp=4", pc_next); else n_pass++;
    set_in(1, 6'd4, 0, 0, '0, 1);
    n_total++; if (stall_o !== 1'b0) $display("FAIL fill_pop_accept got=%0b exp=0", stall_o); else n_pass++;
    n_total++; if (bus.id_pc_o !== 6'd0) $display("FAIL fill_pop_pc got=%0h exp=0", bus.id_pc_o); else n_pass++;
    tick();
    set_in(1, 6'd5, 0, 1, f_inst(6'd4), 0);
    n_total++; if (bus.imem_addr_o !== 6'd4) $display("FAIL fill_addr got=%0h exp=4", bus.imem_addr_o); else n_pass++;
    n_total++; if (stall_o !== 1'b1) $display("FAIL fill_restall got=%0b exp=1", stall_o); else n_pass++;
    tick();
    set_in(1, 6'd5, 0, 0, '0, 0);
    n_total++; if (count_o !== 3'd4) $display("FAIL fill_count2 got=%0d exp=4", count_o); else n_pass++;
    n_total++; if (stall_o !== 1'b1) $display("FAIL fill_stall2 got=%0b exp=1", stall_o); else n_pass++;
    n_total++; if (bus.id_pc_o !== 6'd1) $display("FAIL fill_head got=%0h exp=1", bus.id_pc_o); else n_pass++;
    tick();
  endtask

  task automatic test_flush_drain();
    do_reset();
    set_in(1, 6'd3, 0, 0, '0, 0);
    tick();
    set_in(0, '0, 0, 1, f_inst(6'd3), 0);
    tick();
    set_in(1, 6'd7, 0, 0, '0, 0);
    n_total++; if (stall_o !== 1'b0) $display("FAIL flush_accept7 got=%0b exp=0", stall_o); else n_pass++;
    tick();
    set_in(0, '0, 1, 0, '0, 1);
    n_total++; if (bus.imem_addr_o !== 6'd7) $display("FAIL flush_addr got=%0h exp=7", bus.imem_addr_o); else n_pass++;
    n_total++; if (bus.id_valid_o !== 1'b1) $display("FAIL flush_pre_valid got=%0b exp=1", bus.id_valid_o); else n_pass++;
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 6'd9, 0, (i == 2), 32'hDEADBEEF, 0);
      n_total++; if (bus.id_valid_o !== 1'b0) $display("FAIL flush_valid cyc=%0d got=%0b exp=0", i, bus.id_valid_o); else n_pass++;
      n_total++; if (bus.imem_req_o !== 1'b1) $display("FAIL drain_req cyc=%0d got=%0b exp=1", i, bus.imem_req_o); else n_pass++;
      n_total++; if (bus.imem_addr_o !== 6'd7) $display("FAIL drain_addr cyc=%0d got=%0h exp=7", i, bus.imem_addr_o); else n_pass++;
      n_total++; if (stall_o !== 1'b1) $display("FAIL drain_stall cyc=%0d got=%0b exp=1", i, stall_o); else n_pass++;
      tick();
    end
    set_in(1, 6'd9, 0, 0, '0, 0);
    n_total++; if (count_o !== 3'd0) $display("FAIL drain_count got=%0d exp=0", count_o); else n_pass++;
    n_total++; if (bus.imem_req_o !== 1'b0) $display("FAIL drain_idle got=%0b exp=0", bus.imem_req_o); else n_pass++;
    n_total++; if (stall_o !== 1'b0) $display("FAIL drain_accept got=%0b exp=0", stall_o); else n_pass++;
    tick();
    set_in(0, '0, 0, 0, '0, 0);
    n_total++; if (bus.imem_addr_o !== 6'd9) $display("FAIL drain_newaddr got=%0h exp=9", bus.imem_addr_o); else n_pass++;
    tick();
  endtask

  task automatic test_full_pop_ack();
    logic [ADDR_W-1:0] pc_next = '0;
    int exp_head = 1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, pc_next, 0, m_out, f_inst(m_addr), 0);
      pc_next++;
      tick();
    end
    set_in(1, 6'd4, 0, 1, f_inst(6'd3), 1);
    n_total++; if (count_o !== 3'd3) $display("FAIL fp_count_pre got=%0d exp=3", count_o); else n_pass++;
    n_total++; if (bus.imem_addr_o !== 6'd3) $display("FAIL fp_addr_pre got=%0h exp=3", bus.imem_addr_o); else n_pass++;
    n_total++; if (stall_o !== 1'b0) $display("FAIL fp_accept got=%0b exp=0", stall_o); else n_pass++;
    n_total++; if (bus.id_pc_o !== 6'd0) $display("FAIL fp_head0 got=%0h exp=0", bus.id_pc_o); else n_pass++;
    tick();
    set_in(0, '0, 0, 0, '0, 0);
    n_total++; if (count_o !== 3'd3) $display("FAIL fp_count_post got=%0d exp=3", count_o); else n_pass++;
    n_total++; if (bus.id_pc_o !== 6'd1) $display("FAIL fp_head1 got=%0h exp=1", bus.id_pc_o); else n_pass++;
    n_total++; if (bus.imem_addr_o !== 6'd4) $display("FAIL fp_addr_post got=%0h exp=4", bus.imem_addr_o); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      set_in(0, '0, 0, m_out, f_inst(m_addr), 1);
      if (bus.id_valid_o) begin
        n_total++; if (bus.id_pc_o !== ADDR_W'(exp_head)) $display("FAIL fp_seq_pc got=%0h exp=%0h", bus.id_pc_o, exp_head); else n_pass++;
        n_total++; if (bus.id_inst_o !== f_inst(ADDR_W'(exp_head))) $display("FAIL fp_seq_inst got=%0h exp=%0h", bus.id_inst_o, f_inst(ADDR_W'(exp_head))); else n_pass++;
        exp_head++;
      end
      tick();
    end
    n_total++; if (exp_head !== 5) $display("FAIL fp_drained got=%0d exp=5", exp_head); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [ADDR_W-1:0] pc_next = '0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, pc_next, 0, m_out, f_inst(m_addr), 0);
      pc_next++;
      tick();
    end
    set_in(0, '0, 0, 0, '0, 0);
    n_total++; if (count_o !== 3'd2) $display("FAIL ar_count_pre got=%0d exp=2", count_o); else n_pass++;
    n_total++; if (bus.imem_req_o !== 1'b1) $display("FAIL ar_req_pre got=%0b exp=1", bus.imem_req_o); else n_pass++;
    rst = 1'b0;
    model_reset();
    #1;
    n_total++; if (bus.imem_req_o !== 1'b0) $display("FAIL ar_req got=%0b exp=0", bus.imem_req_o); else n_pass++;
    n_total++; if (bus.id_valid_o !== 1'b0) $display("FAIL ar_valid got=%0b exp=0", bus.id_valid_o); else n_pass++;
    n_total++; if (count_o !== 3'd0) $display("FAIL ar_count got=%0d exp=0", count_o); else n_pass++;
    tick();
    #3;
    rst = 1'b1;
    tick();
    test_single_fetch();
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] e_pc;
    logic [DATA_W-1:0] e_inst;
    bit e_stall;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom % 10) < 7, ADDR_W'($urandom), ($urandom % 20) == 0,
             ($urandom % 2) == 1, $urandom, ($urandom % 10) < 6);
      e_stall = ce_i && !f_accept();
      e_pc    = (mq.size() != 0) ? mq[0][ADDR_W+DATA_W-1:DATA_W] : '0;
      e_inst  = (mq.size() != 0) ? mq[0][DATA_W-1:0] : '0;
      n_total++; if (stall_o !== e_stall) $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", i, stall_o, e_stall); else n_pass++;
      n_total++; if (bus.imem_req_o !== m_out) $display("FAIL rnd_req cyc=%0d got=%0b exp=%0b", i, bus.imem_req_o, m_out); else n_pass++;
      n_total++; if (bus.imem_addr_o !== m_addr) $display("FAIL rnd_addr cyc=%0d got=%0h exp=%0h", i, bus.imem_addr_o, m_addr); else n_pass++;
      n_total++; if (bus.id_valid_o !== (mq.size() != 0)) $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", i, bus.id_valid_o, mq.size() != 0); else n_pass++;
      n_total++; if (bus.id_pc_o !== e_pc) $display("FAIL rnd_pc cyc=%0d got=%0h exp=%0h", i, bus.id_pc_o, e_pc); else n_pass++;
      n_total++; if (bus.id_inst_o !== e_inst) $display("FAIL rnd_inst cyc=%0d got=%0h exp=%0h", i, bus.id_inst_o, e_inst); else n_pass++;
      n_total++; if (count_o !== 3'(mq.size())) $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count_o, mq.size()); else n_pass++;
      tick();
    end
  endtask

  initial begin
    bus.imem_ack_i = 1'b0;
    bus.imem_rdata_i = '0;
    bus.id_ready_i = 1'b0;
    model_reset();
    test_reset();
    test_single_fetch();
    test_streaming();
    test_fill();
    test_flush_drain();
    test_full_pop_ack();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register. It sits between the PC register, instruction memory and the IF/ID boundary.
- Takes pc_i/ce_i and issues one-outstanding-request fetches to instruction memory over a req/ack handshake.
- Buffers the returned {pc, instruction} pairs in a small FIFO and presents them to decode with valid/ready.
- Back-pressures the PC register via stall_o and supports a pipeline flush.

Parameters:
- ADDR_W, 6, width of pc / instruction address
- DATA_W, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- pc_i  in  ADDR_W  fetch address from PC register
- ce_i  in  1  pc_i valid / fetch enable
- stall_o  out  1  PC register must hold pc_i this cycle
- flush_i  in  1  synchronous flush: discard queued and in-flight fetches
- imem_req_o  out  1  memory request, held until ack
- imem_addr_o  out  ADDR_W  request address, stable while imem_req_o=1
- imem_ack_i  in  1  memory completion; valid only while imem_req_o=1
- imem_rdata_i  in  DATA_W  instruction, valid with imem_ack_i
- id_valid_o  out  1  head entry valid
- id_ready_i  in  1  decode accepts head
- id_pc_o  out  ADDR_W  head entry address
- id_inst_o  out  DATA_W  head entry instruction
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, rd/wr pointers=0, imem_req_o=0, imem_addr_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0, count_o=0, stall_o=0. Storage contents are don't-care.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding, result is kept.
  - DRAIN: request outstanding, result is discarded.
- Per-cycle terms:
  - wr = (state==REQ) & imem_ack_i
  - rd = id_valid_o & id_ready_i
  - cnt_nxt = count + wr - rd
- accept = ce_i & ~flush_i & (state==IDLE | wr) & (cnt_nxt < DEPTH).
- stall_o = ce_i & ~accept (combinational; includes the id_ready_i path).
- On accept: imem_addr_o <= pc_i, next state=REQ (also when the current state is REQ with ack). Result: back-to-back fetches at 1/cycle when ack comes every cycle.
- REQ & imem_ack_i & ~accept: next state=IDLE.
- Request outputs: imem_req_o=1 exactly in REQ and DRAIN. imem_addr_o changes only on accept.
- Write path: on wr & ~flush_i, {imem_addr_o, imem_rdata_i} is written at wr_ptr.
- Pointers: wrap modulo DEPTH; full/empty are decided by count, never by the pointers.
- Head outputs: id_valid_o = (count!=0). id_pc_o/id_inst_o show the head entry and stay stable while id_valid_o & ~id_ready_i.
- Latency: accept at cycle N -> imem_req_o=1 at N+1 -> ack at M>=N+1 -> id_valid_o at M+1 (if FIFO was empty).
- Full FIFO with simultaneous rd: the write is allowed because the pop frees the slot (cnt_nxt rule).
- Flush (flush_i=1):
  - count, pointers and id_valid_o clear next cycle; rd is ignored; accept=0.
  - From REQ without ack: next state=DRAIN.
  - From REQ with ack: the data is dropped, next state=IDLE.
- DRAIN: hold imem_req_o/imem_addr_o. On imem_ack_i, discard the data and go to IDLE. No accept in DRAIN (stall_o=ce_i).
- Reset mid-REQ returns to IDLE with imem_req_o=0 immediately. The memory model must tolerate an abandoned request.
- imem_ack_i while in IDLE is ignored.

Test Plan:
- Single fetch, empty FIFO: pc_i=6'h05, ce_i=1 for one cycle, ack 2 cycles after req with rdata=32'h2001000A -> imem_req_o high 2 cycles, addr=5. id_valid_o rises the cycle after ack with id_pc_o=5, id_inst_o=32'h2001000A. stall_o=1 while REQ without ack.
- Streaming: ce_i=1, pc_i=0,1,2..., ack every cycle, id_ready_i=1 -> imem_req_o continuously high, one new pc accepted per cycle. id_pc_o sequence 0,1,2,... with stall_o=0 after the first request.
- Fill: id_ready_i=0, DEPTH=4, ack every cycle -> count_o reaches 4 and stall_o stays 1 thereafter. Raising id_ready_i for one cycle pops pc 0 and permits exactly one further accept.
- Flush in flight: flush_i during REQ for pc 7 with no ack, ack arrives 3 cycles later -> state DRAIN, id_valid_o=0 next cycle, acked data never enqueued. First accept occurs the cycle after the DRAIN ack.
- Full plus simultaneous pop and ack: count=3 with the 4th in REQ, ack coincides with id_ready_i=1 and ce_i=1 -> count stays 3 after write+pop, new pc accepted the same cycle, head advances correctly.
- Async reset mid-operation: rst low between clock edges during REQ with count=2 -> imem_req_o, id_valid_o and count_o go 0 immediately. After release, the first ce_i fetch behaves as in the single-fetch scenario.
